// File: rtl/gpu_layer_pkg.sv
// Shared types and defaults for the layer RAM address generator.
package gpu_layer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_SUM  = 2'd2,
        ST_EMIT = 2'd3
    } state_t;

    localparam logic MODE_TEXT   = 1'b0;
    localparam logic MODE_SPRITE = 1'b1;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DIM_W      = 16;
    localparam int DEF_FRAME_W    = 8;
    localparam int DEF_LEN_W      = 16;
    localparam int DEF_NUM_LAYERS = 4;
    localparam int DEF_CHAR_SHIFT = 1;

    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_addr_mult.sv
// Sprite offset unit: registers frame*height and y*width, then presents
// frame*height*width + y*width + x combinationally for the base-address sum.
module layer_addr_mult #(
    parameter int ADDR_W  = 32,
    parameter int DIM_W   = 16,
    parameter int FRAME_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] frame,
    input  logic [DIM_W-1:0]   height,
    input  logic [DIM_W-1:0]   width,
    input  logic [DIM_W-1:0]   x,
    input  logic [DIM_W-1:0]   y,
    output logic [ADDR_W-1:0]  offset
);

    logic [ADDR_W-1:0] p_frame;
    logic [ADDR_W-1:0] p_row;
    logic [ADDR_W-1:0] frame_e, height_e, width_e, x_e, y_e;

    // Everything widened to ADDR_W so products wrap modulo 2^ADDR_W.
    assign frame_e  = ADDR_W'(frame);
    assign height_e = ADDR_W'(height);
    assign width_e  = ADDR_W'(width);
    assign x_e      = ADDR_W'(x);
    assign y_e      = ADDR_W'(y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_frame <= '0;
            p_row   <= '0;
        end else if (load) begin
            p_frame <= frame_e * height_e;
            p_row   <= y_e * width_e;
        end
    end

    assign offset = p_frame * width_e + p_row + x_e;

endmodule

// File: rtl/layer_addr_gen.sv
// Layer RAM address generator: one fetch command in, LEN word addresses out.
// Define LAYER_ADDR_BOUNDS_CHECK_EN to reject out-of-range sprite commands with an err pulse.
//
//  state | meaning
//  IDLE  | waiting for a command (cmd_ready high unless flushing)
//  MUL   | offset products being registered; bounds check when enabled
//  SUM   | base address loaded into the address register
//  EMIT  | streaming beats, addr increments on each accepted beat
module layer_addr_gen
    import gpu_layer_pkg::*;
#(
    parameter  int ADDR_W     = DEF_ADDR_W,
    parameter  int DIM_W      = DEF_DIM_W,
    parameter  int FRAME_W    = DEF_FRAME_W,
    parameter  int LEN_W      = DEF_LEN_W,
    parameter  int NUM_LAYERS = DEF_NUM_LAYERS,
    parameter  int CHAR_SHIFT = DEF_CHAR_SHIFT,
    localparam int LAYER_W    = tag_width(NUM_LAYERS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [LAYER_W-1:0] cmd_layer,
    input  logic               cmd_sprite,
    input  logic [ADDR_W-1:0]  cmd_start,
    input  logic [FRAME_W-1:0] cmd_frame,
    input  logic [DIM_W-1:0]   cmd_height,
    input  logic [DIM_W-1:0]   cmd_width,
    input  logic [DIM_W-1:0]   cmd_x,
    input  logic [DIM_W-1:0]   cmd_y,
    input  logic [DIM_W-1:0]   cmd_char,
    input  logic [LEN_W-1:0]   cmd_len,
    output logic               addr_valid,
    input  logic               addr_ready,
    output logic [ADDR_W-1:0]  addr,
    output logic [LAYER_W-1:0] addr_layer,
    output logic               addr_last,
    output logic               err
);

    state_t state_q, state_d;

    logic               sprite_q;
    logic [ADDR_W-1:0]  start_q;
    logic [FRAME_W-1:0] frame_q;
    logic [DIM_W-1:0]   height_q, width_q, x_q, y_q, char_q;
    logic [LEN_W-1:0]   remaining_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LAYER_W-1:0] layer_q;
    logic [ADDR_W-1:0]  sprite_off;
    logic [ADDR_W-1:0]  text_off;
    logic               accept;
    logic               beat_done;
    logic               bounds_fail;

    assign cmd_ready  = (state_q == ST_IDLE) & ~flush;
    assign accept     = cmd_valid & cmd_ready;
    assign addr_valid = (state_q == ST_EMIT);
    assign addr_last  = addr_valid & (remaining_q == LEN_W'(1));
    assign beat_done  = addr_valid & addr_ready & ~flush;
    assign addr       = addr_q;
    assign addr_layer = layer_q;
    assign text_off   = ADDR_W'(char_q) << CHAR_SHIFT;

`ifdef LAYER_ADDR_BOUNDS_CHECK_EN
    logic err_q;

    assign bounds_fail = (sprite_q == MODE_SPRITE) &
                         ((x_q >= width_q) | (y_q >= height_q) |
                          (width_q == '0) | (height_q == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_q == ST_MUL) & bounds_fail & ~flush;
        end
    end

    assign err = err_q;
`else
    assign bounds_fail = 1'b0;
    assign err         = 1'b0;
`endif

    layer_addr_mult #(
        .ADDR_W  (ADDR_W),
        .DIM_W   (DIM_W),
        .FRAME_W (FRAME_W)
    ) u_mult (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (state_q == ST_MUL),
        .frame  (frame_q),
        .height (height_q),
        .width  (width_q),
        .x      (x_q),
        .y      (y_q),
        .offset (sprite_off)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_MUL;
            ST_MUL:  state_d = bounds_fail ? ST_IDLE : ST_SUM;
            ST_SUM:  state_d = ST_EMIT;
            ST_EMIT: if (addr_ready && remaining_q == LEN_W'(1)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sprite_q    <= 1'b0;
            start_q     <= '0;
            frame_q     <= '0;
            height_q    <= '0;
            width_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            char_q      <= '0;
            remaining_q <= '0;
            addr_q      <= '0;
            layer_q     <= '0;
        end else begin
            if (accept) begin
                sprite_q    <= cmd_sprite;
                start_q     <= cmd_start;
                frame_q     <= cmd_frame;
                height_q    <= cmd_height;
                width_q     <= cmd_width;
                x_q         <= cmd_x;
                y_q         <= cmd_y;
                char_q      <= cmd_char;
                layer_q     <= cmd_layer;
                remaining_q <= (cmd_len == '0) ? LEN_W'(1) : cmd_len;
            end
            if (state_q == ST_SUM) begin
                addr_q <= (sprite_q == MODE_TEXT) ? start_q + text_off
                                                  : start_q + sprite_off;
            end
            if (beat_done) begin
                addr_q      <= addr_q + ADDR_W'(1);
                remaining_q <= remaining_q - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_layer_addr_gen.sv
// Self-checking bench for layer_addr_gen; build with LAYER_ADDR_BOUNDS_CHECK_EN to exercise the reject path.
module tb_layer_addr_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_layer;
    logic        cmd_sprite;
    logic [31:0] cmd_start;
    logic [7:0]  cmd_frame;
    logic [15:0] cmd_height, cmd_width, cmd_x, cmd_y, cmd_char, cmd_len;
    logic        addr_valid;
    logic        addr_ready;
    logic [31:0] addr;
    logic [1:0]  addr_layer;
    logic        addr_last;
    logic        err;

    layer_addr_gen dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_layer(cmd_layer),
        .cmd_sprite(cmd_sprite), .cmd_start(cmd_start), .cmd_frame(cmd_frame),
        .cmd_height(cmd_height), .cmd_width(cmd_width), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .cmd_char(cmd_char), .cmd_len(cmd_len),
        .addr_valid(addr_valid), .addr_ready(addr_ready), .addr(addr),
        .addr_layer(addr_layer), .addr_last(addr_last), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [1:0]  l;
    } beat_t;
    beat_t exp_q[$];

    int  tests = 0;
    int  fails = 0;
    int  beats = 0;
    int  acc_cyc = 0;
    int  err_cyc = -100;
    bit  first_pend = 0;
    bit  chk_en = 0;
    bit  bp_en = 0;
    int  bp_k = 0;
    logic bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    function automatic logic [31:0] sprite_base(input longint unsigned s, input longint unsigned f,
                                                input longint unsigned h, input longint unsigned w,
                                                input longint unsigned x, input longint unsigned y);
        longint unsigned t;
        t = s + f * h * w + y * w + x;
        return t[31:0];
    endfunction

    function automatic logic [31:0] text_base(input longint unsigned s, input longint unsigned c);
        longint unsigned t;
        t = s + (c << 1);
        return t[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference checker: every presented beat must be the head of the expected stream.
    always @(negedge clk) begin
        if (chk_en && rst_n && !flush) begin
            check("err_pulse", {31'b0, err}, {31'b0, (cyc == err_cyc)});
            if (addr_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", addr, 32'hxxxx_xxxx);
                end else begin
                    check("beat_addr", addr, exp_q[0].a);
                    check("beat_layer", {30'b0, addr_layer}, {30'b0, exp_q[0].l});
                    check("beat_last", {31'b0, addr_last}, {31'b0, (exp_q.size() == 1)});
                    if (first_pend) begin
                        check("first_latency", cyc, acc_cyc + 2);
                        first_pend = 0;
                    end
                    if (addr_ready) begin
                        void'(exp_q.pop_front());
                        beats++;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            addr_ready = bp_pat[bp_k];
            bp_k = (bp_k + 1) % 4;
        end
    end

    task automatic issue(input logic spr, input logic [31:0] st, input int fr, input int h,
                         input int w, input int x, input int y, input int ch, input int len,
                         input logic [1:0] ly, input bit exp_beats, input bit exp_err);
        logic [31:0] base;
        int n;
        @(posedge clk); #1;
        cmd_sprite = spr; cmd_start = st; cmd_frame = fr[7:0];
        cmd_height = h[15:0]; cmd_width = w[15:0]; cmd_x = x[15:0]; cmd_y = y[15:0];
        cmd_char = ch[15:0]; cmd_len = len[15:0]; cmd_layer = ly;
        cmd_valid = 1'b1;
        @(negedge clk);
        check("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        acc_cyc = cyc;
        if (exp_err) err_cyc = acc_cyc + 1;
        if (exp_beats) begin
            base = spr ? sprite_base(st, fr, h, w, x, y) : text_base(st, ch);
            n = (len == 0) ? 1 : len;
            for (int i = 0; i < n; i++) exp_q.push_back('{a: base + 32'(i), l: ly});
            first_pend = 1;
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!addr_valid && cmd_ready) done = 1;
        end
        check("idle_reached", {31'b0, done}, 32'd1);
        check("beats_outstanding", exp_q.size(), 32'd0);
    endtask

    task automatic skip_negedges(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int b0;
        bit quiet;
        rst_n = 1'b0; flush = 1'b0; cmd_valid = 1'b0; cmd_layer = '0; cmd_sprite = 1'b0;
        cmd_start = '0; cmd_frame = '0; cmd_height = '0; cmd_width = '0; cmd_x = '0;
        cmd_y = '0; cmd_char = '0; cmd_len = '0; addr_ready = 1'b1;

        skip_negedges(2);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_addr_valid", {31'b0, addr_valid}, 32'd0);
        check("rst_addr", addr, 32'd0);
        check("rst_addr_layer", {30'b0, addr_layer}, 32'd0);
        check("rst_addr_last", {31'b0, addr_last}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        rst_n = 1'b1;
        chk_en = 1;

        // Sprite burst, ready always high
        issue(1'b1, 32'h1000, 2, 16, 16, 3, 4, 0, 4, 2'd2, 1, 0);
        skip_negedges(3);
        check("t1_first_valid", {31'b0, addr_valid}, 32'd1);
        check("t1_first_addr", addr, 32'h1243);
        check("t1_layer", {30'b0, addr_layer}, 32'd2);
        skip_negedges(3);
        check("t1_last_addr", addr, 32'h1246);
        check("t1_last_flag", {31'b0, addr_last}, 32'd1);
        wait_idle();

        // Text, len 0 -> single beat
        issue(1'b0, 32'h2000, 0, 0, 0, 0, 0, 5, 0, 2'd1, 1, 0);
        skip_negedges(3);
        check("t2_addr", addr, 32'h200A);
        check("t2_last", {31'b0, addr_last}, 32'd1);
        wait_idle();

        // Backpressure 1,0,0,1
        b0 = beats;
        bp_k = 0;
        bp_en = 1;
        issue(1'b1, 32'h1000, 2, 16, 16, 3, 4, 0, 4, 2'd3, 1, 0);
        wait_idle();
        bp_en = 0;
        addr_ready = 1'b1;
        check("t3_beat_count", beats - b0, 32'd4);

        // Address wrap
        issue(1'b0, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0, 4, 2'd0, 1, 0);
        skip_negedges(3);
        check("t4_first", addr, 32'hFFFF_FFFE);
        skip_negedges(3);
        check("t4_wrapped_last", addr, 32'h0000_0001);
        wait_idle();

        // Flush mid-burst after two beats
        b0 = beats;
        issue(1'b0, 32'h3000, 0, 0, 0, 0, 0, 0, 8, 2'd1, 1, 0);
        skip_negedges(3);
        @(posedge clk);
        @(posedge clk); #1;
        flush = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("t5_flush_valid", {31'b0, addr_valid}, 32'd0);
        check("t5_flush_last", {31'b0, addr_last}, 32'd0);
        check("t5_flush_ready", {31'b0, cmd_ready}, 32'd1);
        check("t5_beats_before_flush", beats - b0, 32'd2);

        // Flush wins over cmd_valid in IDLE
        @(posedge clk); #1;
        flush = 1'b1;
        cmd_valid = 1'b1; cmd_sprite = 1'b0; cmd_start = 32'h5000; cmd_len = 16'd2;
        @(negedge clk);
        check("t5_flush_blocks_ready", {31'b0, cmd_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        cmd_valid = 1'b0;
        quiet = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (addr_valid) quiet = 0;
        end
        check("t5_no_accept", {31'b0, quiet}, 32'd1);

        // Async reset mid-burst
        issue(1'b0, 32'h4000, 0, 0, 0, 0, 0, 2, 8, 2'd3, 1, 0);
        skip_negedges(4);
        #2;
        rst_n = 1'b0;
        chk_en = 0;
        exp_q.delete();
        first_pend = 0;
        #1;
        check("t5_rst_valid", {31'b0, addr_valid}, 32'd0);
        check("t5_rst_addr", addr, 32'd0);
        check("t5_rst_layer", {30'b0, addr_layer}, 32'd0);
        check("t5_rst_last", {31'b0, addr_last}, 32'd0);
        check("t5_rst_ready", {31'b0, cmd_ready}, 32'd1);
        check("t5_rst_err", {31'b0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1;

        // Out-of-range sprite x == width
`ifdef LAYER_ADDR_BOUNDS_CHECK_EN
        issue(1'b1, 32'h0, 0, 16, 16, 16, 0, 0, 2, 2'd1, 0, 1);
        skip_negedges(2);
        check("t6_err_pulse", {31'b0, err}, 32'd1);
        check("t6_ready_back", {31'b0, cmd_ready}, 32'd1);
        @(negedge clk);
        check("t6_err_one_cycle", {31'b0, err}, 32'd0);
        check("t6_no_beats", {31'b0, addr_valid}, 32'd0);
`else
        issue(1'b1, 32'h0, 0, 16, 16, 16, 0, 0, 2, 2'd1, 1, 0);
        skip_negedges(3);
        check("t6_unchecked_addr", addr, 32'h10);
        check("t6_unchecked_err", {31'b0, err}, 32'd0);
`endif
        wait_idle();

        // Extra sprite, large start, model-only
        issue(1'b1, 32'h8000_0000, 3, 10, 20, 5, 7, 0, 3, 2'd2, 1, 0);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 500000");
        $fatal(1);
    end

endmodule
